// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the CPU data memory bus. Serves a word-addressed
// RAM at byte addresses [0, RAM_WORDS*4) and one MMIO page at MMIO_BASE that
// holds a 64-bit cycle counter, a console transmit FIFO and a fault-address
// register. Read data is registered and appears one cycle after the request.
//
// MMIO word offsets within the page:
//   0x00 CYCLE_LO       RO  cycle[31:0]; the read also snapshots cycle[63:32]
//   0x04 CYCLE_HI       RO  snapshot taken by the last CYCLE_LO read
//   0x08 CONSOLE_DATA   WO  write with mask bit 0 pushes write_data_i[7:0]
//   0x0C CONSOLE_STATUS RW  {count[3:0], overflow, 0, empty, full}; write clears overflow
//   0x10 FAULT_ADDR     RW  address of the last unmapped access; write clears it
//   0x18 MTIMECMP_LO    RW  (DMEM_TIMER_IRQ_EN only)
//   0x1C MTIMECMP_HI    RW  (DMEM_TIMER_IRQ_EN only)
//
// Optional feature macro: DMEM_TIMER_IRQ_EN
//   Defined   : MTIMECMP registers exist, timer_irq_o = registered (cycle >= mtimecmp).
//   Undefined : offsets 0x18/0x1C are unmapped and fault, timer_irq_o = 0.
//
// Ports:
//   clk_i           in   clock
//   rst_ni          in   asynchronous active-low reset
//   addr_i          in   [31:0] byte address, bits [1:0] ignored
//   read_enable_i   in   read request
//   write_mask_i    in   [3:0] byte write enables, nonzero means write
//   write_data_i    in   [31:0] lane-aligned write data
//   read_data_o     out  [31:0] registered read data, held when not reading
//   console_data_o  out  [7:0] console FIFO head byte (0 when empty)
//   console_valid_o out  console FIFO not empty
//   console_ready_i in   consumer accepts the head byte
//   fault_o         out  one-cycle pulse after an unmapped access
//   timer_irq_o     out  timer compare interrupt
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned RAM_WORDS     = 1024,
    parameter logic [31:0] MMIO_BASE     = 32'hFF00_0000,
    parameter int unsigned CONSOLE_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic        read_enable_i,
    input  logic [3:0]  write_mask_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic [7:0]  console_data_o,
    output logic        console_valid_o,
    input  logic        console_ready_i,
    output logic        fault_o,
    output logic        timer_irq_o
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CON_AW = $clog2(CONSOLE_DEPTH);
    localparam int CNT_W  = CON_AW + 1;

    // Word offsets (addr_i[7:2]) of the MMIO registers.
    localparam logic [5:0] OFF_CYCLE_LO    = 6'h00;
    localparam logic [5:0] OFF_CYCLE_HI    = 6'h01;
    localparam logic [5:0] OFF_CON_DATA    = 6'h02;
    localparam logic [5:0] OFF_CON_STATUS  = 6'h03;
    localparam logic [5:0] OFF_FAULT_ADDR  = 6'h04;
`ifdef DMEM_TIMER_IRQ_EN
    localparam logic [5:0] OFF_MTIMECMP_LO = 6'h06;
    localparam logic [5:0] OFF_MTIMECMP_HI = 6'h07;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       ram [RAM_WORDS];
    logic [7:0]        fifo_mem [CONSOLE_DEPTH];
    logic [63:0]       cycle_q;
    logic [31:0]       hi_snap_q;
    logic [31:0]       fault_addr_q;
    logic [CON_AW-1:0] wr_ptr_q;
    logic [CON_AW-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
`ifdef DMEM_TIMER_IRQ_EN
    logic [63:0]       mtimecmp_q;
    logic              timer_irq_q;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              is_write;
    logic              access;
    logic              ram_hit;
    logic              page_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic              hit_cycle_lo, hit_cycle_hi, hit_con_data, hit_con_status, hit_fault_addr;
`ifdef DMEM_TIMER_IRQ_EN
    logic              hit_cmp_lo, hit_cmp_hi;
`endif
    logic              mmio_hit;
    logic              unmapped;
    logic [31:0]       rd_value;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic [3:0]        status_count;

    assign fifo_full    = (count_q == CNT_W'(CONSOLE_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign status_count = 4'(count_q);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        is_write       = (write_mask_i != 4'b0000);
        access         = read_enable_i || is_write;
        ram_hit        = (addr_i[31:RAM_AW+2] == '0);
        ram_idx        = addr_i[RAM_AW+1:2];
        // RAM wins if a badly chosen MMIO_BASE ever overlaps it.
        page_hit       = !ram_hit && (addr_i[31:8] == MMIO_BASE[31:8]);
        hit_cycle_lo   = page_hit && (addr_i[7:2] == OFF_CYCLE_LO);
        hit_cycle_hi   = page_hit && (addr_i[7:2] == OFF_CYCLE_HI);
        hit_con_data   = page_hit && (addr_i[7:2] == OFF_CON_DATA);
        hit_con_status = page_hit && (addr_i[7:2] == OFF_CON_STATUS);
        hit_fault_addr = page_hit && (addr_i[7:2] == OFF_FAULT_ADDR);
        mmio_hit       = hit_cycle_lo || hit_cycle_hi || hit_con_data
                      || hit_con_status || hit_fault_addr;
`ifdef DMEM_TIMER_IRQ_EN
        hit_cmp_lo     = page_hit && (addr_i[7:2] == OFF_MTIMECMP_LO);
        hit_cmp_hi     = page_hit && (addr_i[7:2] == OFF_MTIMECMP_HI);
        mmio_hit       = mmio_hit || hit_cmp_lo || hit_cmp_hi;
`endif
        unmapped       = access && !ram_hit && !mmio_hit;

        // Unmapped and write-only locations read as zero.
        rd_value = 32'h0;
        if (ram_hit)        rd_value = ram[ram_idx];
        if (hit_cycle_lo)   rd_value = cycle_q[31:0];
        if (hit_cycle_hi)   rd_value = hi_snap_q;
        if (hit_con_status) rd_value = {24'h0, status_count, overflow_q, 1'b0,
                                        fifo_empty, fifo_full};
        if (hit_fault_addr) rd_value = fault_addr_q;
`ifdef DMEM_TIMER_IRQ_EN
        if (hit_cmp_lo)     rd_value = mtimecmp_q[31:0];
        if (hit_cmp_hi)     rd_value = mtimecmp_q[63:32];
`endif

        push_req = hit_con_data && write_mask_i[0];
        pop      = !fifo_empty && console_ready_i;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push_ok  = push_req && (!fifo_full || pop);
    end

    // ------------------------------------------------------------------
    // RAM and FIFO storage
    // ------------------------------------------------------------------
    // NOTE: storage arrays carry no reset; only the control state around
    // them does, which keeps them mappable onto plain RAM macros.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_hit && write_mask_i[k]) begin
                ram[ram_idx][8*k +: 8] <= write_data_i[8*k +: 8];
            end
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= write_data_i[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Read port, counter, fault tracking
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; this is what makes same-word read/write
    // return the old data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_data_o  <= 32'h0;
            cycle_q      <= 64'h0;
            hi_snap_q    <= 32'h0;
            fault_o      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            if (read_enable_i) begin
                read_data_o <= rd_value;
            end
            cycle_q <= cycle_q + 64'd1;
            // The snapshot lets software read a coherent 64-bit value even
            // if the low word carries between the two reads.
            if (read_enable_i && hit_cycle_lo) begin
                hi_snap_q <= cycle_q[63:32];
            end
            fault_o <= unmapped;
            if (unmapped) begin
                fault_addr_q <= addr_i;
            end else if (hit_fault_addr && is_write) begin
                fault_addr_q <= 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (push_ok) wr_ptr_q <= wr_ptr_q + CON_AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + CON_AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end else if (hit_con_status && is_write) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign console_valid_o = !fifo_empty;
    assign console_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Timer compare
    // ------------------------------------------------------------------
`ifdef DMEM_TIMER_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp_q  <= '1;
            timer_irq_q <= 1'b0;
        end else begin
            timer_irq_q <= (cycle_q >= mtimecmp_q);
            for (int k = 0; k < 4; k++) begin
                if (hit_cmp_lo && write_mask_i[k]) begin
                    mtimecmp_q[8*k +: 8] <= write_data_i[8*k +: 8];
                end
                if (hit_cmp_hi && write_mask_i[k]) begin
                    mtimecmp_q[32 + 8*k +: 8] <= write_data_i[8*k +: 8];
                end
            end
        end
    end

    assign timer_irq_o = timer_irq_q;
`else
    assign timer_irq_o = 1'b0;
`endif

endmodule
